// File: rtl/sr_reg_bank.sv
// sr_reg_bank: bank of N independent set/reset flags with active-low
// asynchronous set/reset inputs brought into the clk domain by a
// configurable synchroniser. It also provides edge pulses and sticky
// invalid-input flags.
//
// Parameters:
//   N           number of channels (1..32)
//   SYNC_STAGES synchroniser depth (0..3, 0 = sample inputs directly)
//   CONFLICT    response to S and R both active:
//               0 hold, 1 set, 2 reset, 3 toggle
//   RESET_Q     q value while reset is asserted
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   s_n      per-channel set, active-low, asynchronous to clk
//   r_n      per-channel reset, active-low, asynchronous to clk
//   err_clr  synchronous clear of all err bits
//   q, q_n   channel state and its inverse
//   rise     one-cycle pulse on a q 0->1 change
//   fall     one-cycle pulse on a q 1->0 change
//   err      sticky flag, set when both inputs are seen active
//   err_any  OR of err
module sr_reg_bank #(
    parameter int unsigned  N           = 8,
    parameter int unsigned  SYNC_STAGES = 2,
    parameter int unsigned  CONFLICT    = 0,
    parameter logic [N-1:0] RESET_Q     = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] s_n,
    input  logic [N-1:0] r_n,
    input  logic         err_clr,
    output logic [N-1:0] q,
    output logic [N-1:0] q_n,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] err,
    output logic         err_any
);

    logic [N-1:0] ss_n;
    logic [N-1:0] sr_n;
    logic [N-1:0] q_d;
    logic [N-1:0] q_next;
    logic [N-1:0] both_low;
    logic [N-1:0] err_next;

    // Synchroniser flops reset to 1 so that the inputs read as inactive.
    // Any samples in flight are therefore dropped when reset asserts.
    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign ss_n = s_n;
            assign sr_n = r_n;
        end else begin : g_sync
            logic [N-1:0] s_pipe [SYNC_STAGES];
            logic [N-1:0] r_pipe [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                        s_pipe[k] <= '1;
                        r_pipe[k] <= '1;
                    end
                end else begin
                    s_pipe[0] <= s_n;
                    r_pipe[0] <= r_n;
                    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                        s_pipe[k] <= s_pipe[k-1];
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign ss_n = s_pipe[SYNC_STAGES-1];
            assign sr_n = r_pipe[SYNC_STAGES-1];
        end
    endgenerate

    // Per-channel next state from the synchronised (s, r) pair.
    always_comb begin
        q_next   = q;
        both_low = '0;
        for (int unsigned i = 0; i < N; i++) begin
            case ({ss_n[i], sr_n[i]})
                2'b11:   q_next[i] = q[i];
                2'b01:   q_next[i] = 1'b1;
                2'b10:   q_next[i] = 1'b0;
                default: begin
                    both_low[i] = 1'b1;
                    case (CONFLICT)
                        1:       q_next[i] = 1'b1;
                        2:       q_next[i] = 1'b0;
                        3:       q_next[i] = ~q[i];
                        default: q_next[i] = q[i];
                    endcase
                end
            endcase
        end
    end

    // A fresh invalid condition wins over err_clr on the same edge.
    assign err_next = (err & {N{~err_clr}}) | both_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= RESET_Q;
            q_d <= RESET_Q;
            err <= '0;
        end else begin
            q   <= q_next;
            q_d <= q;
            err <= err_next;
        end
    end

    assign q_n     = ~q;
    assign rise    = q & ~q_d;
    assign fall    = ~q & q_d;
    assign err_any = |err;

endmodule

// File: tb/tb_sr_reg_bank.sv
module tb_sr_reg_bank;

    logic       clk;
    logic       rst_n;
    logic       err_clr;
    logic [7:0] s_n;
    logic [7:0] r_n;

    // Index: 0 CONFLICT=0, 1 CONFLICT=1, 2 CONFLICT=2, 3 CONFLICT=3,
    //        4 RESET_Q=8'h0F, 5 SYNC_STAGES=0
    logic [7:0] q_x    [6];
    logic [7:0] qn_x   [6];
    logic [7:0] rise_x [6];
    logic [7:0] fall_x [6];
    logic [7:0] err_x  [6];
    logic       erra_x [6];

    int checks;
    int failures;

    genvar g;
    generate
        for (g = 0; g < 6; g++) begin : g_dut
            sr_reg_bank #(
                .N           (8),
                .SYNC_STAGES ((g == 5) ? 0 : 2),
                .CONFLICT    ((g < 4) ? g : 0),
                .RESET_Q     ((g == 4) ? 8'h0F : 8'h00)
            ) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .s_n     (s_n),
                .r_n     (r_n),
                .err_clr (err_clr),
                .q       (q_x[g]),
                .q_n     (qn_x[g]),
                .rise    (rise_x[g]),
                .fall    (fall_x[g]),
                .err     (err_x[g]),
                .err_any (erra_x[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        err_clr = 1'b0;
        s_n     = 8'hFF;
        r_n     = 8'hFF;
        tick();
        tick();
        checks++;
        if (q_x[0] !== 8'h00 || qn_x[0] !== 8'hFF) begin
            failures++;
            $display("FAIL reset_q q=%h q_n=%h expected 00/FF", q_x[0], qn_x[0]);
        end
        checks++;
        if (rise_x[0] !== 8'h00 || fall_x[0] !== 8'h00 || err_x[0] !== 8'h00 || erra_x[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags rise=%h fall=%h err=%h err_any=%b expected 0", rise_x[0], fall_x[0], err_x[0], erra_x[0]);
        end
        checks++;
        if (q_x[4] !== 8'h0F || qn_x[4] !== 8'hF0 || rise_x[4] !== 8'h00 || fall_x[4] !== 8'h00) begin
            failures++;
            $display("FAIL reset_val q=%h q_n=%h rise=%h fall=%h expected 0F/F0/00/00", q_x[4], qn_x[4], rise_x[4], fall_x[4]);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (q_x[0] !== 8'h00 || rise_x[0] !== 8'h00 || fall_x[0] !== 8'h00 ||
                q_x[4] !== 8'h0F || rise_x[4] !== 8'h00 || fall_x[4] !== 8'h00) begin
                failures++;
                $display("FAIL reset_release cyc=%0d q=%h/%h rise=%h/%h fall=%h/%h expected 00/0F no pulses",
                         j, q_x[0], q_x[4], rise_x[0], rise_x[4], fall_x[0], fall_x[4]);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] exp_q;
        s_n[3] = 1'b0;
        tick();
        s_n[3] = 1'b1;
        checks++;
        if (q_x[5] !== 8'h08 || rise_x[5] !== 8'h08) begin
            failures++;
            $display("FAIL bypass_set q=%h rise=%h expected 08/08", q_x[5], rise_x[5]);
        end
        for (int j = 2; j <= 4; j++) begin
            tick();
            exp_q = (j >= 3) ? 8'h08 : 8'h00;
            checks++;
            if (q_x[0] !== exp_q || qn_x[0] !== ~exp_q ||
                rise_x[0] !== ((j == 3) ? 8'h08 : 8'h00) || fall_x[0] !== 8'h00) begin
                failures++;
                $display("FAIL set_latency edge=%0d q=%h q_n=%h rise=%h fall=%h expected q=%h",
                         j, q_x[0], qn_x[0], rise_x[0], fall_x[0], exp_q);
            end
        end
        r_n[3] = 1'b0;
        tick();
        r_n[3] = 1'b1;
        for (int j = 2; j <= 4; j++) begin
            tick();
            exp_q = (j >= 3) ? 8'h00 : 8'h08;
            checks++;
            if (q_x[0] !== exp_q || qn_x[0] !== ~exp_q ||
                fall_x[0] !== ((j == 3) ? 8'h08 : 8'h00) || rise_x[0] !== 8'h00) begin
                failures++;
                $display("FAIL reset_latency edge=%0d q=%h q_n=%h rise=%h fall=%h expected q=%h",
                         j, q_x[0], qn_x[0], rise_x[0], fall_x[0], exp_q);
            end
        end
    endtask

    task automatic test_conflict();
        logic exp_c3;
        s_n[0] = 1'b0;
        tick();
        s_n[0] = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (q_x[0][0] !== 1'b1 || q_x[1][0] !== 1'b1 || q_x[2][0] !== 1'b1 || q_x[3][0] !== 1'b1) begin
            failures++;
            $display("FAIL conflict_prep q0=%b%b%b%b expected 1111", q_x[0][0], q_x[1][0], q_x[2][0], q_x[3][0]);
        end
        s_n[0] = 1'b0;
        r_n[0] = 1'b0;
        tick();
        tick();
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j == 1) begin
                s_n[0] = 1'b1;
                r_n[0] = 1'b1;
            end
            exp_c3 = (j % 2 == 1);
            checks++;
            if (q_x[0][0] !== 1'b1 || q_x[1][0] !== 1'b1 || q_x[2][0] !== 1'b0) begin
                failures++;
                $display("FAIL conflict_modes cyc=%0d hold=%b set=%b reset=%b expected 1/1/0",
                         j, q_x[0][0], q_x[1][0], q_x[2][0]);
            end
            checks++;
            if (q_x[3][0] !== exp_c3 || rise_x[3][0] !== exp_c3 || fall_x[3][0] !== !exp_c3) begin
                failures++;
                $display("FAIL conflict_toggle cyc=%0d q=%b rise=%b fall=%b expected q=%b",
                         j, q_x[3][0], rise_x[3][0], fall_x[3][0], exp_c3);
            end
            checks++;
            if (err_x[0][0] !== 1'b1 || err_x[1][0] !== 1'b1 || err_x[2][0] !== 1'b1 || err_x[3][0] !== 1'b1 ||
                erra_x[0] !== 1'b1 || erra_x[3] !== 1'b1) begin
                failures++;
                $display("FAIL conflict_err cyc=%0d err0=%b%b%b%b err_any=%b expected all 1",
                         j, err_x[0][0], err_x[1][0], err_x[2][0], err_x[3][0], erra_x[0]);
            end
        end
        tick();
        checks++;
        if (q_x[3][0] !== 1'b1 || rise_x[3][0] !== 1'b0 || fall_x[3][0] !== 1'b0) begin
            failures++;
            $display("FAIL conflict_end q=%b rise=%b fall=%b expected 1/0/0", q_x[3][0], rise_x[3][0], fall_x[3][0]);
        end
    endtask

    task automatic test_err_clr();
        s_n[5] = 1'b0;
        r_n[5] = 1'b0;
        tick();
        s_n[5] = 1'b1;
        r_n[5] = 1'b1;
        tick();
        tick();
        checks++;
        if (err_x[0] !== 8'h21 || erra_x[0] !== 1'b1) begin
            failures++;
            $display("FAIL err_set err=%h err_any=%b expected 21/1", err_x[0], erra_x[0]);
        end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_x[0] !== 8'h00 || erra_x[0] !== 1'b0) begin
            failures++;
            $display("FAIL err_clear err=%h err_any=%b expected 00/0", err_x[0], erra_x[0]);
        end
        s_n[5] = 1'b0;
        r_n[5] = 1'b0;
        tick();
        s_n[5] = 1'b1;
        r_n[5] = 1'b1;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_x[0] !== 8'h20 || erra_x[0] !== 1'b1) begin
            failures++;
            $display("FAIL err_set_wins err=%h err_any=%b expected 20/1", err_x[0], erra_x[0]);
        end
        tick();
        checks++;
        if (err_x[0] !== 8'h20) begin
            failures++;
            $display("FAIL err_sticky err=%h expected 20", err_x[0]);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_x[0] !== 8'h00 || err_x[3] !== 8'h00) begin
            failures++;
            $display("FAIL err_final_clear err=%h/%h expected 00", err_x[0], err_x[3]);
        end
    endtask

    task automatic test_independence();
        r_n = 8'h00;
        tick();
        r_n = 8'hFF;
        tick();
        tick();
        tick();
        checks++;
        if (q_x[0] !== 8'h00) begin
            failures++;
            $display("FAIL indep_prep q=%h expected 00", q_x[0]);
        end
        s_n = 8'hAA;
        r_n = 8'h55;
        tick();
        s_n = 8'hFF;
        r_n = 8'hFF;
        tick();
        tick();
        checks++;
        if (q_x[0] !== 8'h55 || qn_x[0] !== 8'hAA || rise_x[0] !== 8'h55 || fall_x[0] !== 8'h00 || err_x[0] !== 8'h00) begin
            failures++;
            $display("FAIL indep q=%h q_n=%h rise=%h fall=%h err=%h expected 55/AA/55/00/00",
                     q_x[0], qn_x[0], rise_x[0], fall_x[0], err_x[0]);
        end
        tick();
        checks++;
        if (q_x[0] !== 8'h55 || rise_x[0] !== 8'h00) begin
            failures++;
            $display("FAIL indep_pulse q=%h rise=%h expected 55/00", q_x[0], rise_x[0]);
        end
    endtask

    task automatic test_reset_mid();
        s_n = 8'h00;
        tick();
        s_n = 8'hFF;
        tick();
        tick();
        checks++;
        if (q_x[0] !== 8'hFF) begin
            failures++;
            $display("FAIL mid_prep q=%h expected FF", q_x[0]);
        end
        s_n = 8'h00;
        r_n = 8'h00;
        tick();
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (q_x[0] !== 8'h00 || err_x[0] !== 8'h00 || erra_x[0] !== 1'b0 || q_x[3] !== 8'h00 || err_x[3] !== 8'h00) begin
            failures++;
            $display("FAIL mid_async q=%h/%h err=%h/%h err_any=%b expected 00",
                     q_x[0], q_x[3], err_x[0], err_x[3], erra_x[0]);
        end
        checks++;
        if (rise_x[0] !== 8'h00 || fall_x[0] !== 8'h00 || q_x[4] !== 8'h0F) begin
            failures++;
            $display("FAIL mid_async_flags rise=%h fall=%h q_rq=%h expected 00/00/0F", rise_x[0], fall_x[0], q_x[4]);
        end
        s_n = 8'hFD;
        r_n = 8'hFF;
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            tick();
            checks++;
            if (q_x[0] !== ((j == 3) ? 8'h02 : 8'h00) || rise_x[0] !== ((j == 3) ? 8'h02 : 8'h00) ||
                fall_x[0] !== 8'h00 || fall_x[3] !== 8'h00 || err_x[0] !== 8'h00) begin
                failures++;
                $display("FAIL mid_release edge=%0d q=%h rise=%h fall=%h err=%h", j, q_x[0], rise_x[0], fall_x[0], err_x[0]);
            end
        end
        s_n = 8'hFF;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_latency();
        test_conflict();
        test_err_clr();
        test_independence();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
